// File: rtl/shift_add_multiplier_pkg.sv
// Shared ALU definitions used by the shift-add multiplier: state encoding,
// default datapath width and a width helper for the step counter.
package shift_add_multiplier_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mul_state_t;

    localparam int ALU_WIDTH = 16;

    function automatic int clog2(input int n);
        int w;
        w = 0;
        while ((32'sd1 << w) < n) begin
            w = w + 1;
        end
        if (w < 1) begin
            w = 1;
        end else begin
            w = w;
        end
        return w;
    endfunction

endpackage

// File: rtl/shift_add_multiplier_if.sv
// Start/ready operand and result bundle shared by the ALU control (master)
// and the multiplier (slave).
interface shift_add_multiplier_if
    import shift_add_multiplier_pkg::*;
#(
    parameter int N = ALU_WIDTH
);
    logic             start;
    logic             sign;
    logic [N-1:0]     multiplicand;
    logic [N-1:0]     multiplier;
    logic [2*N-1:0]   product;
    logic             busy;
    logic             ready;

    modport master (
        output start, sign, multiplicand, multiplier,
        input  product, busy, ready
    );

    modport slave (
        input  start, sign, multiplicand, multiplier,
        output product, busy, ready
    );
endinterface

// File: rtl/shift_add_multiplier_mul_step.sv
// One radix-2 iteration: conditionally add the multiplicand into the upper
// accumulator half, then shift {carry, acc_hi, mplr} right by one.
module mul_step
    import shift_add_multiplier_pkg::*;
#(
    parameter int N = ALU_WIDTH
) (
    input  logic [N-1:0] acc_hi_i,
    input  logic [N-1:0] mplr_i,
    input  logic [N-1:0] mcand_i,
    output logic [N-1:0] acc_hi_o,
    output logic [N-1:0] mplr_o
);
    logic [N:0] sum_s;

    // Carry lands in bit N so the shift below never loses it.
    always_comb begin
        sum_s = {1'b0, acc_hi_i};
        if (mplr_i[0]) begin
            sum_s = {1'b0, acc_hi_i} + {1'b0, mcand_i};
        end else begin
            sum_s = {1'b0, acc_hi_i};
        end
        acc_hi_o = sum_s[N:1];
        mplr_o   = {sum_s[0], mplr_i[N-1:1]};
    end
endmodule

// File: rtl/shift_add_multiplier.sv
// Sequential shift-and-add multiplier, one multiplier bit per clock.
// Signed operation is compiled in only when MUL_SIGNED_EN is defined.
module shift_add_multiplier
    import shift_add_multiplier_pkg::*;
#(
    parameter int N = ALU_WIDTH
) (
    input  logic                       clk,
    input  logic                       rst,
    shift_add_multiplier_if.slave      bus
);
    localparam int CNT_W = clog2(N);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N - 1);

    mul_state_t       state_q;
    logic [N-1:0]     acc_hi_q;
    logic [N-1:0]     mplr_q;
    logic [N-1:0]     mcand_q;
    logic             neg_q;
    logic [CNT_W-1:0] count_q;
    logic [2*N-1:0]   product_q;
    logic             busy_q;
    logic             ready_q;

    logic [N-1:0]     acc_hi_d;
    logic [N-1:0]     mplr_d;
    logic [2*N-1:0]   product_d;
    logic [N-1:0]     mcand_mag_s;
    logic [N-1:0]     mplr_mag_s;
    logic             neg_s;

`ifdef MUL_SIGNED_EN
    // Unsigned view of the negation keeps the most negative value exact (0x8000 -> 0x8000).
    function automatic logic [N-1:0] magnitude(input logic [N-1:0] v, input logic s);
        if (s && v[N-1]) begin
            return (~v) + {{(N-1){1'b0}}, 1'b1};
        end else begin
            return v;
        end
    endfunction

    assign mcand_mag_s = magnitude(bus.multiplicand, bus.sign);
    assign mplr_mag_s  = magnitude(bus.multiplier, bus.sign);
    assign neg_s       = bus.sign & (bus.multiplicand[N-1] ^ bus.multiplier[N-1]);
    assign product_d   = neg_q ? ((~{acc_hi_d, mplr_d}) + {{(2*N-1){1'b0}}, 1'b1})
                               : {acc_hi_d, mplr_d};
`else
    assign mcand_mag_s = bus.multiplicand;
    assign mplr_mag_s  = bus.multiplier;
    assign neg_s       = 1'b0;
    assign product_d   = {acc_hi_d, mplr_d};
`endif

    mul_step #(.N(N)) u_step (
        .acc_hi_i (acc_hi_q),
        .mplr_i   (mplr_q),
        .mcand_i  (mcand_q),
        .acc_hi_o (acc_hi_d),
        .mplr_o   (mplr_d)
    );

    // Control FSM, datapath registers and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            acc_hi_q  <= '0;
            mplr_q    <= '0;
            mcand_q   <= '0;
            neg_q     <= 1'b0;
            count_q   <= '0;
            product_q <= '0;
            busy_q    <= 1'b0;
            ready_q   <= 1'b0;
        end else begin
            ready_q <= 1'b0;
            case (state_q)
                IDLE, DONE: begin
                    if (bus.start) begin
                        acc_hi_q <= '0;
                        mplr_q   <= mplr_mag_s;
                        mcand_q  <= mcand_mag_s;
                        neg_q    <= neg_s;
                        count_q  <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= RUN;
                    end else begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                RUN: begin
                    acc_hi_q <= acc_hi_d;
                    mplr_q   <= mplr_d;
                    count_q  <= count_q + {{(CNT_W-1){1'b0}}, 1'b1};
                    if (count_q == LAST_CNT) begin
                        product_q <= product_d;
                        busy_q    <= 1'b0;
                        ready_q   <= 1'b1;
                        state_q   <= DONE;
                    end else begin
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.product = product_q;
    assign bus.busy    = busy_q;
    assign bus.ready   = ready_q;
endmodule

// File: tb/tb_shift_add_multiplier.sv
// Directed self-checking bench for shift_add_multiplier (N=16); signed
// expectations follow whether MUL_SIGNED_EN is defined for the build.
module tb_shift_add_multiplier;
    localparam int N = 16;
    localparam int LAT = 16;

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    shift_add_multiplier_if #(.N(N)) bus ();

    shift_add_multiplier #(.N(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_op(input logic [15:0] a, input logic [15:0] b, input logic s);
        bus.start        = 1'b1;
        bus.multiplicand = a;
        bus.multiplier   = b;
        bus.sign         = s;
        tick();
        bus.start = 1'b0;
    endtask

    // Called right after the accept edge; returns edges until ready.
    task automatic wait_ready(output int cyc, output logic busy_ok);
        cyc = 0;
        busy_ok = bus.busy;
        while (cyc < 40) begin
            tick();
            cyc++;
            if (bus.ready === 1'b1) break;
            busy_ok = busy_ok & bus.busy;
        end
    endtask

    task automatic test_reset();
        bus.start = 1'b1; bus.sign = 1'b0;
        bus.multiplicand = 16'd6; bus.multiplier = 16'd7;
        rst = 1'b1;
        tick(); tick();
        checks++; if (bus.product !== 32'h0) begin errors++; $display("FAIL reset_product got=%h exp=%h", bus.product, 32'h0); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
        checks++; if (bus.ready !== 1'b0) begin errors++; $display("FAIL reset_ready got=%b exp=0", bus.ready); end
        rst = 1'b0; bus.start = 1'b0;
        tick();
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_nostart got=%b exp=0", bus.busy); end
    endtask

    task automatic test_unsigned();
        logic [15:0] va [3];
        logic [15:0] vb [3];
        logic [31:0] ve [3];
        int cyc;
        logic bok;
        va = '{16'd6, 16'hFFFF, 16'h0000};
        vb = '{16'd7, 16'hFFFF, 16'h1234};
        ve = '{32'h0000_002A, 32'hFFFE_0001, 32'h0000_0000};
        for (int i = 0; i < 3; i++) begin
            start_op(va[i], vb[i], 1'b0);
            wait_ready(cyc, bok);
            checks++; if (cyc !== LAT) begin errors++; $display("FAIL u_latency[%0d] got=%0d exp=%0d", i, cyc, LAT); end
            checks++; if (bus.product !== ve[i]) begin errors++; $display("FAIL u_product[%0d] got=%h exp=%h", i, bus.product, ve[i]); end
            checks++; if (bok !== 1'b1 || bus.busy !== 1'b0) begin errors++; $display("FAIL u_busy[%0d] got=%b/%b exp=1/0", i, bok, bus.busy); end
            tick();
            checks++; if (bus.ready !== 1'b0) begin errors++; $display("FAIL u_pulse[%0d] got=%b exp=0", i, bus.ready); end
        end
    endtask

    task automatic test_signed();
        logic [15:0] va [4];
        logic [15:0] vb [4];
        logic        vs [4];
        logic [31:0] ve [4];
        int cyc;
        logic bok;
        va = '{16'hFFFD, 16'h8000, 16'hFFFD, 16'h8000};
        vb = '{16'h0005, 16'h8000, 16'h0005, 16'h0001};
        vs = '{1'b1, 1'b1, 1'b0, 1'b1};
`ifdef MUL_SIGNED_EN
        ve = '{32'hFFFF_FFF1, 32'h4000_0000, 32'h0004_FFF1, 32'hFFFF_8000};
`else
        ve = '{32'h0004_FFF1, 32'h4000_0000, 32'h0004_FFF1, 32'h0000_8000};
`endif
        for (int i = 0; i < 4; i++) begin
            start_op(va[i], vb[i], vs[i]);
            wait_ready(cyc, bok);
            checks++; if (cyc !== LAT) begin errors++; $display("FAIL s_latency[%0d] got=%0d exp=%0d", i, cyc, LAT); end
            checks++; if (bus.product !== ve[i]) begin errors++; $display("FAIL s_product[%0d] got=%h exp=%h", i, bus.product, ve[i]); end
            tick();
        end
    endtask

    task automatic test_ignore_start();
        int cyc;
        logic bok;
        start_op(16'd100, 16'd200, 1'b0);
        for (int i = 0; i < 4; i++) tick();
        bus.start = 1'b1; bus.multiplicand = 16'd3; bus.multiplier = 16'd3;
        tick();
        bus.start = 1'b0; bus.multiplicand = 16'h5555; bus.multiplier = 16'hAAAA;
        wait_ready(cyc, bok);
        checks++; if (cyc !== LAT - 5) begin errors++; $display("FAIL ign_latency got=%0d exp=%0d", cyc, LAT - 5); end
        checks++; if (bus.product !== 32'h0000_4E20) begin errors++; $display("FAIL ign_product got=%h exp=%h", bus.product, 32'h0000_4E20); end
        tick(); tick();
        checks++; if (bus.busy !== 1'b0 || bus.ready !== 1'b0) begin errors++; $display("FAIL ign_idle got=%b/%b exp=0/0", bus.busy, bus.ready); end
    endtask

    task automatic test_back_to_back();
        int cyc;
        logic bok;
        start_op(16'd5, 16'd6, 1'b0);
        wait_ready(cyc, bok);
        checks++; if (bus.product !== 32'h0000_001E) begin errors++; $display("FAIL b2b_first got=%h exp=%h", bus.product, 32'h0000_001E); end
        start_op(16'd3, 16'd3, 1'b0);
        checks++; if (bus.product !== 32'h0000_001E) begin errors++; $display("FAIL b2b_hold got=%h exp=%h", bus.product, 32'h0000_001E); end
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL b2b_accept got=%b exp=1", bus.busy); end
        wait_ready(cyc, bok);
        checks++; if (cyc !== LAT) begin errors++; $display("FAIL b2b_latency got=%0d exp=%0d", cyc, LAT); end
        checks++; if (bus.product !== 32'h0000_0009) begin errors++; $display("FAIL b2b_second got=%h exp=%h", bus.product, 32'h0000_0009); end
        tick();
    endtask

    task automatic test_reset_mid();
        int cyc;
        logic bok;
        logic seen;
        start_op(16'd1000, 16'd1000, 1'b0);
        for (int i = 0; i < 8; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (bus.busy !== 1'b0 || bus.product !== 32'h0) begin errors++; $display("FAIL mid_abort got=%b/%h exp=0/0", bus.busy, bus.product); end
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            seen = seen | bus.ready;
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL mid_noready got=%b exp=0", seen); end
        start_op(16'd1000, 16'd1000, 1'b0);
        wait_ready(cyc, bok);
        checks++; if (cyc !== LAT) begin errors++; $display("FAIL mid_latency got=%0d exp=%0d", cyc, LAT); end
        checks++; if (bus.product !== 32'h000F_4240) begin errors++; $display("FAIL mid_product got=%h exp=%h", bus.product, 32'h000F_4240); end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst = 1'b1;
        bus.start = 1'b0;
        bus.sign = 1'b0;
        bus.multiplicand = 16'h0;
        bus.multiplier = 16'h0;
        test_reset();
        test_unsigned();
        test_signed();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
